bcd_mod_cntr: RTL and testbench



---
 rtl/watch_pkg.sv | 29 ++
 rtl/bcd_digit.sv | 56 +++++
 rtl/bcd_mod_cntr.sv | 155 +++++++++++++++
 tb/tb_bcd_mod_cntr.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/watch_pkg.sv
// Shared types and constants for the watch datapath BCD counters.
package watch_pkg;

  // One BCD digit.
  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX  = 4'd9;
  localparam bcd_t BCD_ZERO = 4'd0;

  // Common modulus values for chained time-of-day stages.
  localparam int SEC_MOD  = 32'd60;
  localparam int MIN_MOD  = 32'd60;
  localparam int HR24_MOD = 32'd24;
  localparam int HR12_MOD = 32'd12;

  // True when a digit holds a legal BCD code.
  function automatic logic bcd_ok(input bcd_t d);
    return (d <= BCD_MAX);
  endfunction

  // True when the two-digit value m:l is strictly greater than max_m:max_l.
  // Assumes both digits of each pair are legal BCD, so a digit-wise compare
  // is exact without converting to binary.
  function automatic logic pair_gt(input bcd_t m, input bcd_t l,
                                   input bcd_t max_m, input bcd_t max_l);
    return (m > max_m) || ((m == max_m) && (l > max_l));
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// Single BCD digit register: load, increment, decrement, with a
// caller-supplied value taken when the digit rolls past 9 or below 0.
module bcd_digit
  import watch_pkg::*;
(
  input  logic clk,
  input  logic clr,
  input  logic inc,
  input  logic dec,
  input  logic load,
  input  bcd_t din,
  input  bcd_t wrap_val,
  output bcd_t q,
  output logic at_max,
  output logic at_zero
);

  bcd_t q_q;
  bcd_t q_d;

  // Next digit value: load beats inc beats dec; otherwise hold.
  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = din;
    end else if (inc) begin
      if (q_q >= BCD_MAX) begin
        q_d = wrap_val;
      end else begin
        q_d = q_q + 4'd1;
      end
    end else if (dec) begin
      if (q_q == BCD_ZERO) begin
        q_d = wrap_val;
      end else begin
        q_d = q_q - 4'd1;
      end
    end else begin
      q_d = q_q;
    end
  end

  // Digit register with synchronous clear.
  always_ff @(posedge clk) begin
    if (clr) begin
      q_q <= BCD_ZERO;
    end else begin
      q_q <= q_d;
    end
  end

  assign q       = q_q;
  assign at_max  = (q_q == BCD_MAX);
  assign at_zero = (q_q == BCD_ZERO);

endmodule

// File: rtl/bcd_mod_cntr.sv
// Two-digit BCD modulo-N up/down counter with synchronous load, load
// validation and a combinational terminal count for same-clock cascading.
module bcd_mod_cntr
  import watch_pkg::*;
#(
  parameter int MODULUS = 60
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       ce,
  input  logic       up,
  input  logic       load,
  input  logic [3:0] din_lsb,
  input  logic [3:0] din_msb,
  output logic [3:0] lsb,
  output logic [3:0] msb,
  output logic       tc,
  output logic       load_err
);

  localparam int   MAX_VAL = MODULUS - 32'd1;
  localparam bcd_t MAX_MSB = 4'(MAX_VAL / 32'd10);
  localparam bcd_t MAX_LSB = 4'(MAX_VAL % 32'd10);

  // Refuse to elaborate a modulus the two-digit datapath cannot represent.
  if ((MODULUS < 32'd2) || (MODULUS > 32'd100)) begin : g_bad_modulus
    $error("bcd_mod_cntr: MODULUS must be in 2..100");
  end

  bcd_t lsb_s;
  bcd_t msb_s;
  logic lsb_at_max;
  logic lsb_at_zero;
  logic msb_at_max;
  logic msb_at_zero;

  logic val_at_max;
  logic val_at_zero;
  logic val_illegal;
  logic din_valid;

  logic lsb_inc;
  logic lsb_dec;
  logic msb_inc;
  logic msb_dec;
  logic dig_load;
  bcd_t lsb_din;
  bcd_t msb_din;
  bcd_t lsb_wrap;
  logic load_err_d;
  logic load_err_q;

  assign val_at_max  = (msb_s == MAX_MSB) && (lsb_s == MAX_LSB);
  assign val_at_zero = msb_at_zero && lsb_at_zero;
  // Non-BCD digits or a value past MAX can only come from upset; the next
  // count edge forces 00 regardless of direction.
  assign val_illegal = !bcd_ok(lsb_s) || !bcd_ok(msb_s) ||
                       pair_gt(msb_s, lsb_s, MAX_MSB, MAX_LSB);
  assign din_valid   = bcd_ok(din_lsb) && bcd_ok(din_msb) &&
                       !pair_gt(din_msb, din_lsb, MAX_MSB, MAX_LSB);

  // Units digit rolls 9->0 counting up and 0->9 counting down.
  assign lsb_wrap = up ? BCD_ZERO : BCD_MAX;

  // Digit control: load, then count; modulus wraps and recovery use load.
  always_comb begin
    lsb_inc    = 1'b0;
    lsb_dec    = 1'b0;
    msb_inc    = 1'b0;
    msb_dec    = 1'b0;
    dig_load   = 1'b0;
    lsb_din    = din_lsb;
    msb_din    = din_msb;
    load_err_d = 1'b0;
    if (load) begin
      if (din_valid) begin
        dig_load = 1'b1;
        lsb_din  = din_lsb;
        msb_din  = din_msb;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (ce) begin
      if (val_illegal) begin
        dig_load = 1'b1;
        lsb_din  = BCD_ZERO;
        msb_din  = BCD_ZERO;
      end else if (up) begin
        if (val_at_max) begin
          dig_load = 1'b1;
          lsb_din  = BCD_ZERO;
          msb_din  = BCD_ZERO;
        end else begin
          lsb_inc = 1'b1;
          // Carry into tens; the tens guard only matters at 99, which is
          // already caught as MAX above.
          msb_inc = lsb_at_max && !msb_at_max;
        end
      end else begin
        if (val_at_zero) begin
          dig_load = 1'b1;
          lsb_din  = MAX_LSB;
          msb_din  = MAX_MSB;
        end else begin
          lsb_dec = 1'b1;
          msb_dec = lsb_at_zero && !msb_at_zero;
        end
      end
    end else begin
      dig_load = 1'b0;
    end
  end

  bcd_digit u_lsb (
    .clk      (clk),
    .clr      (clr),
    .inc      (lsb_inc),
    .dec      (lsb_dec),
    .load     (dig_load),
    .din      (lsb_din),
    .wrap_val (lsb_wrap),
    .q        (lsb_s),
    .at_max   (lsb_at_max),
    .at_zero  (lsb_at_zero)
  );

  bcd_digit u_msb (
    .clk      (clk),
    .clr      (clr),
    .inc      (msb_inc),
    .dec      (msb_dec),
    .load     (dig_load),
    .din      (msb_din),
    .wrap_val (BCD_ZERO),
    .q        (msb_s),
    .at_max   (msb_at_max),
    .at_zero  (msb_at_zero)
  );

  // One-cycle flag for a rejected load.
  always_ff @(posedge clk) begin
    if (clr) begin
      load_err_q <= 1'b0;
    end else begin
      load_err_q <= load_err_d;
    end
  end

  assign lsb      = lsb_s;
  assign msb      = msb_s;
  assign load_err = load_err_q;
  // Combinational so the next stage on the same clock steps with this wrap.
  assign tc       = ce && !clr && !load && (up ? val_at_max : val_at_zero);

endmodule

// File: tb/tb_bcd_mod_cntr.sv
// Directed scoreboard bench for bcd_mod_cntr across several moduli and a
// seconds->minutes->hours cascade.
module tb_bcd_mod_cntr;

  // 0:M60  1:M24  2:M100  3:M7  4:sec(60)  5:min(60)  6:hr(24)
  logic       clk = 1'b0;
  logic       clr;
  logic       up;
  logic       ce_a   [0:4];
  logic       load_a [0:6];
  logic [3:0] dl_a   [0:6];
  logic [3:0] dm_a   [0:6];
  logic [3:0] lsb_a  [0:6];
  logic [3:0] msb_a  [0:6];
  logic       tc_a   [0:6];
  logic       err_a  [0:6];

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    int         id;
    logic [3:0] em;
    logic [3:0] el;
    logic       ee;
  } exp_t;

  exp_t sbq[$];

  always #5 clk = ~clk;

  bcd_mod_cntr #(.MODULUS(60)) u60 (
    .clk(clk), .clr(clr), .ce(ce_a[0]), .up(up), .load(load_a[0]),
    .din_lsb(dl_a[0]), .din_msb(dm_a[0]), .lsb(lsb_a[0]), .msb(msb_a[0]),
    .tc(tc_a[0]), .load_err(err_a[0]));
  bcd_mod_cntr #(.MODULUS(24)) u24 (
    .clk(clk), .clr(clr), .ce(ce_a[1]), .up(up), .load(load_a[1]),
    .din_lsb(dl_a[1]), .din_msb(dm_a[1]), .lsb(lsb_a[1]), .msb(msb_a[1]),
    .tc(tc_a[1]), .load_err(err_a[1]));
  bcd_mod_cntr #(.MODULUS(100)) u100 (
    .clk(clk), .clr(clr), .ce(ce_a[2]), .up(up), .load(load_a[2]),
    .din_lsb(dl_a[2]), .din_msb(dm_a[2]), .lsb(lsb_a[2]), .msb(msb_a[2]),
    .tc(tc_a[2]), .load_err(err_a[2]));
  bcd_mod_cntr #(.MODULUS(7)) u7 (
    .clk(clk), .clr(clr), .ce(ce_a[3]), .up(up), .load(load_a[3]),
    .din_lsb(dl_a[3]), .din_msb(dm_a[3]), .lsb(lsb_a[3]), .msb(msb_a[3]),
    .tc(tc_a[3]), .load_err(err_a[3]));
  bcd_mod_cntr #(.MODULUS(60)) u_sec (
    .clk(clk), .clr(clr), .ce(ce_a[4]), .up(up), .load(load_a[4]),
    .din_lsb(dl_a[4]), .din_msb(dm_a[4]), .lsb(lsb_a[4]), .msb(msb_a[4]),
    .tc(tc_a[4]), .load_err(err_a[4]));
  bcd_mod_cntr #(.MODULUS(60)) u_min (
    .clk(clk), .clr(clr), .ce(tc_a[4]), .up(up), .load(load_a[5]),
    .din_lsb(dl_a[5]), .din_msb(dm_a[5]), .lsb(lsb_a[5]), .msb(msb_a[5]),
    .tc(tc_a[5]), .load_err(err_a[5]));
  bcd_mod_cntr #(.MODULUS(24)) u_hr (
    .clk(clk), .clr(clr), .ce(tc_a[5]), .up(up), .load(load_a[6]),
    .din_lsb(dl_a[6]), .din_msb(dm_a[6]), .lsb(lsb_a[6]), .msb(msb_a[6]),
    .tc(tc_a[6]), .load_err(err_a[6]));

  // Queue the value (decimal) and load_err expected after the next edge.
  task automatic expect_val(input string tag, input int id, input int val,
                            input logic err);
    exp_t e;
    e.tag = tag;
    e.id  = id;
    e.em  = 4'(val / 10);
    e.el  = 4'(val % 10);
    e.ee  = err;
    sbq.push_back(e);
  endtask

  // Advance one edge, then compare every queued expectation.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    while (sbq.size() != 0) begin
      e = sbq.pop_front();
      checks++;
      assert ({msb_a[e.id], lsb_a[e.id], err_a[e.id]} === {e.em, e.el, e.ee})
      else begin
        errors++;
        $error("FAIL %s id=%0d got %h%h err=%b want %h%h err=%b", e.tag, e.id,
               msb_a[e.id], lsb_a[e.id], err_a[e.id], e.em, e.el, e.ee);
      end
    end
  endtask

  // Check the combinational terminal count after inputs settle.
  task automatic chk_tc(input string tag, input int id, input logic exp);
    #1;
    checks++;
    assert (tc_a[id] === exp)
    else begin
      errors++;
      $error("FAIL %s id=%0d tc got %b want %b", tag, id, tc_a[id], exp);
    end
  endtask

  task automatic ld(input int id, input logic [3:0] m, input logic [3:0] l);
    load_a[id] = 1'b1;
    dm_a[id]   = m;
    dl_a[id]   = l;
  endtask

  initial begin
    clr = 1'b1;
    up  = 1'b0;
    for (int i = 0; i < 5; i++) ce_a[i] = 1'b0;
    for (int i = 0; i < 7; i++) begin
      load_a[i] = 1'b0;
      dl_a[i]   = 4'd0;
      dm_a[i]   = 4'd0;
    end

    // Reset, two cycles
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < 7; i++) expect_val("reset", i, 0, 1'b0);
      tick();
    end

    // Full count-up lap with wrap 59 -> 00
    clr = 1'b0;
    ce_a[0] = 1'b1;
    up = 1'b1;
    for (int i = 0; i < 60; i++) begin
      chk_tc("up_tc", 0, (i == 59));
      expect_val("up_cnt", 0, (i + 1) % 60, 1'b0);
      tick();
    end

    // Down wrap and borrow
    ce_a[0] = 1'b0;
    ld(0, 4'd0, 4'd0);
    expect_val("ld00", 0, 0, 1'b0);
    tick();
    load_a[0] = 1'b0;
    ce_a[0] = 1'b1;
    up = 1'b0;
    chk_tc("dn_tc00", 0, 1'b1);
    expect_val("dn_wrap", 0, 59, 1'b0);
    tick();
    chk_tc("dn_tc59", 0, 1'b0);
    expect_val("dn_58", 0, 58, 1'b0);
    tick();
    ce_a[0] = 1'b0;
    ld(0, 4'd5, 4'd0);
    expect_val("ld50", 0, 50, 1'b0);
    tick();
    load_a[0] = 1'b0;
    ce_a[0] = 1'b1;
    expect_val("borrow49", 0, 49, 1'b0);
    tick();
    ce_a[0] = 1'b0;

    // Load rules
    ld(0, 4'd3, 4'd7);
    expect_val("ld37", 0, 37, 1'b0);
    tick();
    ld(0, 4'd6, 4'd0);
    expect_val("ld60_rej", 0, 37, 1'b1);
    tick();
    load_a[0] = 1'b0;
    expect_val("err_pulse1", 0, 37, 1'b0);
    tick();
    ld(0, 4'd2, 4'hA);
    expect_val("ld2A_rej", 0, 37, 1'b1);
    tick();
    load_a[0] = 1'b0;
    expect_val("err_pulse2", 0, 37, 1'b0);
    tick();
    ld(0, 4'hA, 4'd0);
    expect_val("ldA0_rej", 0, 37, 1'b1);
    tick();
    load_a[0] = 1'b0;
    expect_val("err_pulse3", 0, 37, 1'b0);
    tick();
    ld(0, 4'd5, 4'd9);
    expect_val("ld59", 0, 59, 1'b0);
    tick();
    ld(0, 4'd1, 4'd2);
    ce_a[0] = 1'b1;
    up = 1'b1;
    chk_tc("ld_ce_tc", 0, 1'b0);
    expect_val("ld_beats_ce", 0, 12, 1'b0);
    tick();
    load_a[0] = 1'b0;
    ce_a[0] = 1'b0;

    // clr beats load and count
    ld(0, 4'd4, 4'd5);
    expect_val("ld45", 0, 45, 1'b0);
    tick();
    clr = 1'b1;
    ld(0, 4'd6, 4'd0);
    ce_a[0] = 1'b1;
    chk_tc("clr_tc", 0, 1'b0);
    expect_val("clr_prio", 0, 0, 1'b0);
    tick();
    clr = 1'b0;
    load_a[0] = 1'b0;
    ce_a[0] = 1'b0;
    expect_val("clr_hold", 0, 0, 1'b0);
    tick();

    // Illegal-state recovery in both directions
    force u60.u_lsb.q_q = 4'd12;
    #1;
    release u60.u_lsb.q_q;
    ce_a[0] = 1'b1;
    up = 1'b1;
    expect_val("recover_up", 0, 0, 1'b0);
    tick();
    force u60.u_msb.q_q = 4'd7;
    #1;
    release u60.u_msb.q_q;
    up = 1'b0;
    expect_val("recover_dn", 0, 0, 1'b0);
    tick();
    ce_a[0] = 1'b0;

    // MODULUS=24
    ld(1, 4'd2, 4'd3);
    expect_val("m24_ld23", 1, 23, 1'b0);
    tick();
    load_a[1] = 1'b0;
    ce_a[1] = 1'b1;
    up = 1'b1;
    chk_tc("m24_tc_up", 1, 1'b1);
    expect_val("m24_up_wrap", 1, 0, 1'b0);
    tick();
    up = 1'b0;
    chk_tc("m24_tc_dn", 1, 1'b1);
    expect_val("m24_dn_wrap", 1, 23, 1'b0);
    tick();
    ce_a[1] = 1'b0;

    // MODULUS=100
    ld(2, 4'd9, 4'd9);
    expect_val("m100_ld99", 2, 99, 1'b0);
    tick();
    load_a[2] = 1'b0;
    ce_a[2] = 1'b1;
    up = 1'b1;
    chk_tc("m100_tc", 2, 1'b1);
    expect_val("m100_wrap", 2, 0, 1'b0);
    tick();
    up = 1'b0;
    expect_val("m100_dn", 2, 99, 1'b0);
    tick();
    ce_a[2] = 1'b0;

    // MODULUS=7
    ld(3, 4'd0, 4'd6);
    expect_val("m7_ld6", 3, 6, 1'b0);
    tick();
    ld(3, 4'd0, 4'd7);
    expect_val("m7_ld7_rej", 3, 6, 1'b1);
    tick();
    load_a[3] = 1'b0;
    ce_a[3] = 1'b1;
    up = 1'b1;
    chk_tc("m7_tc", 3, 1'b1);
    expect_val("m7_wrap", 3, 0, 1'b0);
    tick();
    up = 1'b0;
    expect_val("m7_dn", 3, 6, 1'b0);
    tick();
    ce_a[3] = 1'b0;

    // Cascade 23:59:59 -> 00:00:00 on one edge
    ld(4, 4'd5, 4'd9);
    ld(5, 4'd5, 4'd9);
    ld(6, 4'd2, 4'd3);
    expect_val("cas_sec59", 4, 59, 1'b0);
    expect_val("cas_min59", 5, 59, 1'b0);
    expect_val("cas_hr23", 6, 23, 1'b0);
    tick();
    for (int i = 4; i < 7; i++) load_a[i] = 1'b0;
    ce_a[4] = 1'b1;
    up = 1'b1;
    chk_tc("cas_tc_sec", 4, 1'b1);
    chk_tc("cas_tc_min", 5, 1'b1);
    chk_tc("cas_tc_hr", 6, 1'b1);
    expect_val("cas_sec00", 4, 0, 1'b0);
    expect_val("cas_min00", 5, 0, 1'b0);
    expect_val("cas_hr00", 6, 0, 1'b0);
    tick();
    chk_tc("cas_tc_min_idle", 5, 1'b0);
    expect_val("cas_sec01", 4, 1, 1'b0);
    expect_val("cas_min_hold", 5, 0, 1'b0);
    expect_val("cas_hr_hold", 6, 0, 1'b0);
    tick();
    ce_a[4] = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
